// File: rtl/transfer_sequencer_pkg.sv
// Shared types, bus size codes and burst sizing helper for the transfer sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    WR_REQ  = 3'd4,
    WR_WAIT = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } seq_state_t;

  localparam logic [3:0] SZ_8W = 4'd9;
  localparam logic [3:0] SZ_4W = 4'd8;
  localparam logic [3:0] SZ_2W = 4'd3;

  function automatic logic [5:0] burst_bytes(input logic [3:0] size);
    case (size)
      SZ_8W:   burst_bytes = 6'd32;
      SZ_4W:   burst_bytes = 6'd16;
      default: burst_bytes = 6'd8;
    endcase
  endfunction

endpackage

// File: rtl/transfer_sequencer_if.sv
// Descriptor, status and read/write machine handshake bundle of the transfer sequencer.
interface transfer_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              start_i;
  logic [ADDR_W-1:0] src_addr_i;
  logic [ADDR_W-1:0] dst_addr_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic              done_o;
  logic              error_o;
  logic              rd_req_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              wr_req_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [3:0]        size_o;
  logic              rd_done_i;
  logic              wr_done_i;
  logic              bus_error_i;

  modport slave (
    input  start_i, src_addr_i, dst_addr_i, len_i, rd_done_i, wr_done_i, bus_error_i,
    output busy_o, done_o, error_o, rd_req_o, rd_addr_o, wr_req_o, wr_addr_o, size_o
  );

  modport master (
    output start_i, src_addr_i, dst_addr_i, len_i, rd_done_i, wr_done_i, bus_error_i,
    input  busy_o, done_o, error_o, rd_req_o, rd_addr_o, wr_req_o, wr_addr_o, size_o
  );
endinterface

// File: rtl/transfer_sequencer_burst_size_sel.sv
// Picks the largest burst (8/4/2 words) that fits in the remaining byte count.
module burst_size_sel
  import seq_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [LEN_W-1:0] rem_i,
  output logic [3:0]       size_o
);

  // Largest-first selection; any nonzero multiple of 8 fits at least a 2-word burst
  always_comb begin
    size_o = SZ_2W;
    if (rem_i >= LEN_W'(32)) begin
      size_o = SZ_8W;
    end else if (rem_i >= LEN_W'(16)) begin
      size_o = SZ_4W;
    end else begin
      size_o = SZ_2W;
    end
  end

endmodule

// File: rtl/transfer_sequencer.sv
// Runs one DMA descriptor as a series of read-then-write bursts through the
// read and write machines, reporting completion or error with a single pulse.
module transfer_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  transfer_sequencer_if.slave bus
);

  seq_state_t        state_r;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [LEN_W-1:0]  rem_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [3:0]        size_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic              rd_req_r;
  logic              wr_req_r;

  logic [LEN_W-1:0]  burst_len_s;
  logic [LEN_W-1:0]  rem_next_s;
  logic [LEN_W-1:0]  sel_rem_s;
  logic [ADDR_W-1:0] step_s;
  logic [ADDR_W-1:0] src_next_s;
  logic [ADDR_W-1:0] dst_next_s;
  logic [3:0]        sel_size_s;
  logic              misalign_s;
  logic              rem_zero_s;
  logic              rem_last_s;

  // Per-burst arithmetic; address sums wrap at ADDR_W bits by construction
  always_comb begin
    burst_len_s = LEN_W'(burst_bytes(size_r));
    step_s      = ADDR_W'(burst_bytes(size_r));
    rem_next_s  = rem_r - burst_len_s;
    src_next_s  = src_r + step_s;
    dst_next_s  = dst_r + step_s;
    misalign_s  = (rem_r[2:0] != 3'd0) || (src_r[2:0] != 3'd0) || (dst_r[2:0] != 3'd0);
    rem_zero_s  = (rem_r == {LEN_W{1'b0}});
    rem_last_s  = (rem_next_s == {LEN_W{1'b0}});
    if (state_r == CHECK) begin
      sel_rem_s = rem_r;
    end else begin
      sel_rem_s = rem_next_s;
    end
  end

  burst_size_sel #(.LEN_W(LEN_W)) u_size_sel (
    .rem_i  (sel_rem_s),
    .size_o (sel_size_s)
  );

  // Sequencer FSM; pulses clear by default and are set on entry to their state
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      src_r     <= {ADDR_W{1'b0}};
      dst_r     <= {ADDR_W{1'b0}};
      rem_r     <= {LEN_W{1'b0}};
      rd_addr_r <= {ADDR_W{1'b0}};
      wr_addr_r <= {ADDR_W{1'b0}};
      size_r    <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      rd_req_r  <= 1'b0;
      wr_req_r  <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      rd_req_r <= 1'b0;
      wr_req_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            src_r   <= bus.src_addr_i;
            dst_r   <= bus.dst_addr_i;
            rem_r   <= bus.len_i;
            busy_r  <= 1'b1;
            state_r <= CHECK;
          end
        end
        CHECK: begin
          if (bus.bus_error_i || (!rem_zero_s && misalign_s)) begin
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ERR;
          end else if (rem_zero_s) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end else begin
            size_r    <= sel_size_s;
            rd_addr_r <= src_r;
            rd_req_r  <= 1'b1;
            state_r   <= RD_REQ;
          end
        end
        RD_REQ, WR_REQ: begin
          if (bus.bus_error_i) begin
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ERR;
          end else if (state_r == RD_REQ) begin
            state_r <= RD_WAIT;
          end else begin
            state_r <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.bus_error_i) begin
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ERR;
          end else if (bus.rd_done_i) begin
            wr_addr_r <= dst_r;
            wr_req_r  <= 1'b1;
            state_r   <= WR_REQ;
          end
        end
        WR_WAIT: begin
          if (bus.bus_error_i) begin
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ERR;
          end else if (bus.wr_done_i) begin
            src_r <= src_next_s;
            dst_r <= dst_next_s;
            rem_r <= rem_next_s;
            if (rem_last_s) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= DONE;
            end else begin
              size_r    <= sel_size_s;
              rd_addr_r <= src_next_s;
              rd_req_r  <= 1'b1;
              state_r   <= RD_REQ;
            end
          end
        end
        DONE, ERR: begin
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o    = busy_r;
  assign bus.done_o    = done_r;
  assign bus.error_o   = error_r;
  assign bus.rd_req_o  = rd_req_r;
  assign bus.rd_addr_o = rd_addr_r;
  assign bus.wr_req_o  = wr_req_r;
  assign bus.wr_addr_o = wr_addr_r;
  assign bus.size_o    = size_r;

endmodule
